// File: rtl/avalon_mem_slave_if.sv
// Avalon-MM bus bundle between the master under test and the memory model.
// Signals: read/write command, word address, writedata, byteenable (master
// driven); waitrequest, readdatavalid, readdata (slave driven).
interface avalon_mem_slave_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) ();
  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     writedata;
  logic [DATA_W/8-1:0]   byteenable;
  logic                  waitrequest;
  logic                  readdatavalid;
  logic [DATA_W-1:0]     readdata;

  modport master (
    output read, write, address, writedata, byteenable,
    input  waitrequest, readdatavalid, readdata
  );

  modport slave (
    input  read, write, address, writedata, byteenable,
    output waitrequest, readdatavalid, readdata
  );
endinterface

// File: rtl/avalon_mem_slave.sv
// Avalon-MM slave memory model: programmable wait states per command,
// fixed-latency pipelined reads, byte-enabled writes, bounded outstanding reads.
// Ports: clock, reset (async, active high), bus (avalon_mem_slave_if.slave).

// One byte column of the memory. Contents start at zero and survive reset.
module avalon_mem_slave_lane #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4
) (
  input  logic             clock,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);
  logic [7:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clock)
    if (we) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module avalon_mem_slave #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 4,
  parameter int DEPTH        = 16,
  parameter int WAIT_CYCLES  = 2,
  parameter int READ_LATENCY = 1,
  parameter int MAX_PENDING  = 4
) (
  input  logic              clock,
  input  logic              reset,
  avalon_mem_slave_if.slave bus
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int WC_W      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam int PND_W     = $clog2(MAX_PENDING + 1);
  localparam int STAGES    = READ_LATENCY - 1;

  typedef enum logic {WAIT, READY} state_t;

  state_t           state, state_nx;
  logic [WC_W-1:0]  wcnt, wcnt_nx;
  logic [PND_W-1:0] pending;
  logic             cmd, stall, rd_acc, wr_acc, in_range;
  logic [IDX_W-1:0] idx;

  logic [NUM_LANES-1:0]       lane_we;
  logic [NUM_LANES-1:0][7:0]  lane_rd;
  logic [DATA_W-1:0]          rd_word;

  logic [STAGES:0]              vld_pipe;
  logic [STAGES:0][DATA_W-1:0]  dat_pipe;

  assign cmd      = bus.read | bus.write;
  // A read cannot start counting its wait states while the return slots are full.
  assign stall    = bus.read & (pending == PND_W'(MAX_PENDING));
  assign rd_acc   = (state == READY) & bus.read;
  assign wr_acc   = (state == READY) & bus.write;
  assign in_range = 32'(bus.address) < 32'(DEPTH);
  assign idx      = bus.address[IDX_W-1:0];

  // ---- wait-state FSM ----
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= WAIT;
      wcnt  <= '0;
    end else begin
      state <= state_nx;
      wcnt  <= wcnt_nx;
    end

  always_comb begin
    state_nx = state;
    wcnt_nx  = wcnt;
    unique case (state)
      WAIT: begin
        if (!cmd)                                 wcnt_nx = '0;
        else if (stall)                           wcnt_nx = wcnt;
        else if (wcnt == WC_W'(WAIT_CYCLES - 1)) begin
          state_nx = READY;
          wcnt_nx  = '0;
        end else                                  wcnt_nx = wcnt + 1'b1;
      end
      // Either the command is accepted here or the master dropped it;
      // both cases start a fresh wait period.
      READY: state_nx = WAIT;
    endcase
  end

  assign bus.waitrequest = (state == WAIT);

  // ---- outstanding read count ----
  always_ff @(posedge clock or posedge reset)
    if (reset) pending <= '0;
    else
      case ({rd_acc, bus.readdatavalid})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: ;
      endcase

  // ---- memory, one column per byte lane ----
  assign lane_we = {NUM_LANES{wr_acc & in_range}} & bus.byteenable;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    avalon_mem_slave_lane #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_lane (
      .clock (clock),
      .we    (lane_we[l]),
      .idx   (idx),
      .wdata (bus.writedata[8*l +: 8]),
      .rdata (lane_rd[l])
    );
  end

  assign rd_word = in_range ? DATA_W'(lane_rd) : '0;

  // ---- read return pipeline ----
  // Data stages only advance alongside a valid bit, so the last stage (the
  // readdata output) holds its value between beats.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      vld_pipe <= '0;
      dat_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_acc;
      if (rd_acc) dat_pipe[0] <= rd_word;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        if (vld_pipe[i-1]) dat_pipe[i] <= dat_pipe[i-1];
      end
    end

  assign bus.readdatavalid = vld_pipe[STAGES];
  assign bus.readdata      = dat_pipe[STAGES];
endmodule

// File: tb/tb_avalon_mem_slave.sv
// Self-checking bench for avalon_mem_slave: directed scenarios followed by a
// randomized command stream, checked against a word-array reference model and
// a queue of expected read returns with their due cycles.
module tb_avalon_mem_slave;
  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 4;
  localparam int DEPTH        = 10;
  localparam int WAIT_CYCLES  = 2;
  localparam int READ_LATENCY = 5;
  localparam int MAX_PENDING  = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;

  avalon_mem_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  avalon_mem_slave #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_CYCLES),
    .READ_LATENCY(READ_LATENCY), .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // reference model
  logic [31:0] ref_mem [16];
  logic [31:0] exp_data [$];
  int          exp_due  [$];
  int          acc_due  [$];   // due cycle of every read accepted since reset
  logic [31:0] last_rd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  // reads accepted before cycle c that have not returned before cycle c
  function automatic int pend_at(input int c);
    int n = 0;
    foreach (acc_due[i]) if (acc_due[i] >= c) n++;
    return n;
  endfunction

  // ---- return monitor ----
  always @(negedge clock) begin
    if (reset) begin
      chk("rst_waitrequest", bus.waitrequest, 1'b1);
      chk("rst_readdatavalid", bus.readdatavalid, 1'b0);
      chk("rst_readdata", bus.readdata, '0);
      last_rd = '0;
    end else if (bus.readdatavalid) begin
      if (exp_data.size() == 0) chk("spurious_rdv", bus.readdatavalid, 1'b0);
      else begin
        chk("rd_data", bus.readdata, exp_data.pop_front());
        chk("rd_cycle", cyc, exp_due.pop_front());
      end
      last_rd = bus.readdata;
    end else begin
      chk("rd_hold", bus.readdata, last_rd);
      if (exp_due.size() > 0 && exp_due[0] <= cyc) begin
        chk("missing_rdv", bus.readdatavalid, 1'b1);
        void'(exp_data.pop_front());
        void'(exp_due.pop_front());
      end
    end
  end

  // ---- stimulus helpers; the bench sits at negedge+1 between steps ----
  task automatic drive(input bit rd, input bit wr, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    bus.read       = rd;
    bus.write      = wr;
    bus.address    = a;
    bus.writedata  = d;
    bus.byteenable = be;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
    repeat (n) begin @(negedge clock); #1; end
  endtask

  // Present a command in the current cycle and hold it until accepted.
  // Each cycle the expected waitrequest comes from counting cycles in which
  // the command was present and not blocked by a full set of pending reads.
  task automatic cmd(input bit is_wr, input logic [3:0] a,
                     input logic [31:0] d, input logic [3:0] be);
    int  cnt  = 0;
    bit  done = 0;
    int  acc;
    logic [31:0] w;
    drive(!is_wr, is_wr, a, d, be);
    for (int k = 0; k < 200 && !done; k++) begin
      if (!(!is_wr && pend_at(cyc) == MAX_PENDING)) cnt++;
      @(negedge clock);
      chk("waitrequest", bus.waitrequest, (cnt == WAIT_CYCLES) ? 1'b0 : 1'b1);
      if (!bus.waitrequest) done = 1;
      else #1;
    end
    if (!done) begin
      chk("cmd_timeout", bus.waitrequest, 1'b0);
      return;
    end
    acc = cyc;
    #1;
    if (is_wr) begin
      if (a < DEPTH) begin
        w = ref_mem[a];
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
        ref_mem[a] = w;
      end
    end else begin
      exp_data.push_back((a < DEPTH) ? ref_mem[a] : 32'h0);
      exp_due.push_back(acc + READ_LATENCY);
      acc_due.push_back(acc + READ_LATENCY);
    end
    @(negedge clock);
    chk("waitrequest_after_accept", bus.waitrequest, 1'b1);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 60 && exp_data.size() > 0; k++) begin
      @(negedge clock); #1;
    end
    chk("drain", exp_data.size(), 0);
  endtask

  initial begin
    logic [3:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    foreach (ref_mem[i]) ref_mem[i] = '0;

    // reset with a read held high, then the first read completes
    drive(1'b1, 1'b0, 4'h0, 32'h0, 4'h0);
    repeat (3) @(negedge clock);
    #1 reset = 1'b0;
    cmd(1'b0, 4'h0, 32'h0, 4'h0);
    idle(1);
    drain();

    // write then read, then byte-enabled overwrite
    cmd(1'b1, 4'h3, 32'hDEADBEEF, 4'hF);
    cmd(1'b0, 4'h3, 32'h0, 4'h0);
    idle(1);
    drain();
    cmd(1'b1, 4'h3, 32'h11223344, 4'h5);
    cmd(1'b0, 4'h3, 32'h0, 4'h0);
    idle(1);
    drain();

    // back-to-back held reads that run into the pending limit
    for (int i = 0; i < 5; i++) cmd(1'b1, 4'(i + 4), $urandom, 4'hF);
    for (int i = 0; i < 5; i++) cmd(1'b0, 4'(i + 4), 32'h0, 4'h0);
    idle(1);
    drain();

    // out of range accesses
    cmd(1'b1, 4'd9, 32'hA5A5_5A5A, 4'hF);
    cmd(1'b1, 4'd12, 32'h5, 4'hF);
    cmd(1'b0, 4'd12, 32'h0, 4'h0);
    cmd(1'b0, 4'd9, 32'h0, 4'h0);
    idle(1);
    drain();

    // randomized command stream
    for (int n = 0; n < 40; n++) begin
      a  = 4'($urandom_range(0, 15));
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      cmd(($urandom_range(0, 2) == 0), a, d, be);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end
    idle(1);
    drain();

    // reset one cycle after a read is accepted: the read never returns
    cmd(1'b1, 4'h3, 32'hCAFE_F00D, 4'hC);
    cmd(1'b0, 4'h3, 32'h0, 4'h0);
    reset = 1'b1;
    idle(0);
    exp_data.delete();
    exp_due.delete();
    acc_due.delete();
    repeat (2) begin @(negedge clock); #1; end
    reset = 1'b0;
    idle(READ_LATENCY + 4);
    cmd(1'b0, 4'h3, 32'h0, 4'h0);
    idle(1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
